// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 system-bus controllers: FSM states,
// register offsets, read-miss pattern and the frame parity rule.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [31:0] ADDR_TX_BYTE = 32'h0000_0000;
    localparam logic [31:0] ADDR_STATUS  = 32'h0000_0004;
    localparam logic [31:0] ADDR_FLAGS   = 32'h0000_0008;
    localparam logic [31:0] ADDR_SRST    = 32'h0000_0024;

    localparam logic [31:0] READ_MISS_DATA = 32'hdead_beef;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 kclk/kdata lines plus a kclk
// falling-edge detector; clr_i returns every flop to its reset value.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic kclk_i,
    input  logic kdata_i,
    output logic kclk_o,
    output logic kdata_o,
    output logic kclk_fall_o
);

    logic [1:0] kclk_sync_q, kclk_sync_d;
    logic [1:0] kdata_sync_q, kdata_sync_d;
    logic       kclk_prev_q, kclk_prev_d;

    always_comb begin
        kclk_sync_d  = {kclk_sync_q[0], kclk_i};
        kdata_sync_d = {kdata_sync_q[0], kdata_i};
        kclk_prev_d  = kclk_sync_q[1];
        if (clr_i) begin
            kclk_sync_d  = '0;
            kdata_sync_d = '0;
            kclk_prev_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            kclk_sync_q  <= '0;
            kdata_sync_q <= '0;
            kclk_prev_q  <= 1'b0;
        end else begin
            kclk_sync_q  <= kclk_sync_d;
            kdata_sync_q <= kdata_sync_d;
            kclk_prev_q  <= kclk_prev_d;
        end
    end

    assign kclk_o      = kclk_sync_q[1];
    assign kdata_o     = kdata_sync_q[1];
    assign kclk_fall_o = kclk_prev_q & ~kclk_sync_q[1];

endmodule

// File: rtl/ps2_tx_sb_ctrl.sv
// Host-to-device PS/2 command transmitter on the system bus: inhibits the
// clock, issues the request, shifts out the frame, checks the device ACK.
module ps2_tx_sb_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        req_i,
    input  logic [31:0] write_data_i,
    input  logic        write_enable_i,
    output logic [31:0] read_data_o,
    output logic        interrupt_request_o,
    input  logic        interrupt_return_i,
    input  logic        kclk_i,
    input  logic        kdata_i,
    output logic        kclk_oe_o,
    output logic        kdata_oe_o
);

    ps2_tx_state_e state_q, state_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          kclk_oe_q, kclk_oe_d;
    logic          kdata_oe_q, kdata_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          dropped_q, dropped_d;

    logic kclk_s, kdata_s, kclk_fall;
    logic soft_rst, wr_tx, rd, timeout;

    assign soft_rst = req_i & write_enable_i & (addr_i == ADDR_SRST) & (write_data_i == 32'd1);
    assign wr_tx    = req_i & write_enable_i & (addr_i == ADDR_TX_BYTE);
    assign rd       = req_i & ~write_enable_i;

    ps2_line_sync u_line_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_i),
        .clr_i      (soft_rst),
        .kclk_i     (kclk_i),
        .kdata_i    (kdata_i),
        .kclk_o     (kclk_s),
        .kdata_o    (kdata_s),
        .kclk_fall_o(kclk_fall)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_d       = cnt_q;
        tx_byte_d   = tx_byte_q;
        read_data_d = read_data_q;
        kclk_oe_d   = kclk_oe_q;
        kdata_oe_d  = kdata_oe_q;
        done_d      = done_q;
        err_d       = err_q;
        dropped_d   = dropped_q;
        timeout     = 1'b0;

        if (rd) begin
            case (addr_i)
                ADDR_TX_BYTE: read_data_d = {24'd0, tx_byte_q};
                ADDR_STATUS:  read_data_d = {31'd0, state_q != ST_IDLE};
                ADDR_FLAGS:   read_data_d = {29'd0, dropped_q, err_q, done_q};
                default:      read_data_d = READ_MISS_DATA;
            endcase
        end

        // Clears are applied first so that any set below overrides them.
        if (rd && addr_i == ADDR_FLAGS) begin
            done_d    = 1'b0;
            err_d     = 1'b0;
            dropped_d = 1'b0;
        end
        if (interrupt_return_i) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (wr_tx && state_q != ST_IDLE) dropped_d = 1'b1;

        if (state_q inside {ST_REQ, ST_SEND, ST_ACK, ST_WAIT_IDLE}) begin
            if (kclk_fall)                                cnt_d = '0;
            else if (cnt_q == 32'(TIMEOUT_CYCLES - 1))    timeout = 1'b1;
            else                                          cnt_d = cnt_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_tx) begin
                    tx_byte_d = write_data_i[7:0];
                    if (write_data_i <= 32'd255) begin
                        shift_d   = {1'b1, odd_parity(write_data_i[7:0]), write_data_i[7:0]};
                        done_d    = 1'b0;
                        err_d     = 1'b0;
                        kclk_oe_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_INHIBIT;
                    end
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
                    kdata_oe_d = 1'b1;
                    kclk_oe_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_REQ;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_REQ: begin
                if (kclk_fall) begin
                    kdata_oe_d = ~shift_q[0];
                    shift_d    = shift_q >> 1;
                    bit_cnt_d  = 4'd1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                // The stop bit is the tenth bit shifted out; it releases the line.
                if (kclk_fall) begin
                    kdata_oe_d = ~shift_q[0];
                    shift_d    = shift_q >> 1;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (kclk_fall) begin
                    if (!kdata_s) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (kclk_s && kdata_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout) begin
            err_d      = 1'b1;
            kclk_oe_d  = 1'b0;
            kdata_oe_d = 1'b0;
            state_d    = ST_IDLE;
        end

        if (soft_rst) begin
            state_d     = ST_IDLE;
            shift_d     = '0;
            bit_cnt_d   = '0;
            cnt_d       = '0;
            tx_byte_d   = '0;
            read_data_d = '0;
            kclk_oe_d   = 1'b0;
            kdata_oe_d  = 1'b0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            dropped_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            tx_byte_q   <= '0;
            read_data_q <= '0;
            kclk_oe_q   <= 1'b0;
            kdata_oe_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            tx_byte_q   <= tx_byte_d;
            read_data_q <= read_data_d;
            kclk_oe_q   <= kclk_oe_d;
            kdata_oe_q  <= kdata_oe_d;
            done_q      <= done_d;
            err_q       <= err_d;
            dropped_q   <= dropped_d;
        end
    end

    assign read_data_o         = read_data_q;
    assign interrupt_request_o = done_q | err_q;
    assign kclk_oe_o           = kclk_oe_q;
    assign kdata_oe_o          = kdata_oe_q;

endmodule

// File: tb/tb_ps2_tx_sb_ctrl.sv
// Directed and randomized bench for ps2_tx_sb_ctrl with a PS/2 device model
// on wired-AND lines and a frame model derived from the PS/2 framing rules.
module tb_ps2_tx_sb_ctrl;

    localparam int unsigned INHIBIT = 20;
    localparam int unsigned TIMEOUT = 300;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        req_i = 1'b0;
    logic [31:0] write_data_i = '0;
    logic        write_enable_i = 1'b0;
    logic [31:0] read_data_o;
    logic        interrupt_request_o;
    logic        interrupt_return_i = 1'b0;
    logic        kclk_oe_o, kdata_oe_o;
    logic        dev_kclk = 1'b1;
    logic        dev_kdata = 1'b1;
    logic        kclk_line, kdata_line;

    int unsigned n_assert = 0;
    int unsigned n_fail = 0;

    assign kclk_line  = dev_kclk & ~kclk_oe_o;
    assign kdata_line = dev_kdata & ~kdata_oe_o;

    always #5 clk_i = ~clk_i;

    ps2_tx_sb_ctrl #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .addr_i             (addr_i),
        .req_i              (req_i),
        .write_data_i       (write_data_i),
        .write_enable_i     (write_enable_i),
        .read_data_o        (read_data_o),
        .interrupt_request_o(interrupt_request_o),
        .interrupt_return_i (interrupt_return_i),
        .kclk_i             (kclk_line),
        .kdata_i            (kdata_line),
        .kclk_oe_o          (kclk_oe_o),
        .kdata_oe_o         (kdata_oe_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        cyc(1);
        req_i = 1'b1; write_enable_i = 1'b1; addr_i = a; write_data_i = d;
        cyc(1);
        req_i = 1'b0; write_enable_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        cyc(1);
        req_i = 1'b1; write_enable_i = 1'b0; addr_i = a;
        cyc(1);
        req_i = 1'b0;
        d = read_data_o;
    endtask

    // Expected host oe per frame slot: start, 8 data bits LSB first, odd parity, stop.
    function automatic logic [10:0] model_oe(input logic [7:0] b);
        logic [10:0] v;
        int unsigned ones = 0;
        v = '0;
        v[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v[1+i] = (b & (8'd1 << i)) == 0;
            ones += ((b >> i) & 8'd1) != 0 ? 1 : 0;
        end
        v[9]  = (ones % 2) == 1;
        v[10] = 1'b0;
        return v;
    endfunction

    task automatic wait_req(output logic ok);
        int unsigned w = 0;
        while (!(kdata_oe_o === 1'b1 && kclk_oe_o === 1'b0) && w < 200) begin
            cyc(1);
            w++;
        end
        ok = (w < 200);
    endtask

    task automatic dev_fall();
        cyc(4); dev_kclk = 1'b0; cyc(6);
    endtask

    task automatic device_frame(input logic ack_low, output logic [10:0] seen, output logic ok);
        seen = '0;
        wait_req(ok);
        if (!ok) return;
        seen[0] = kdata_oe_o;
        for (int i = 1; i <= 10; i++) begin
            dev_fall();
            seen[i] = kdata_oe_o;
            cyc(2);
            dev_kclk = 1'b1;
        end
        cyc(4);
        dev_kdata = ack_low ? 1'b0 : 1'b1;
        dev_fall();
        dev_kclk = 1'b1;
        cyc(2);
        dev_kdata = 1'b1;
    endtask

    task automatic wait_irq(output logic ok);
        int unsigned w = 0;
        while (interrupt_request_o !== 1'b1 && w < 50) begin
            cyc(1);
            w++;
        end
        ok = (w < 50);
    endtask

    function automatic logic [7:0] captured(input logic [10:0] seen);
        logic [7:0] b = '0;
        for (int i = 0; i < 8; i++) b[i] = ~seen[1+i];
        return b;
    endfunction

    initial begin
        logic [10:0] seen;
        logic        ok;
        logic [31:0] rdat;
        logic [7:0]  b;
        int unsigned n;

        cyc(3);
        chk("reset_kclk_oe", {31'd0, kclk_oe_o}, 32'd0);
        chk("reset_kdata_oe", {31'd0, kdata_oe_o}, 32'd0);
        chk("reset_irq", {31'd0, interrupt_request_o}, 32'd0);
        chk("reset_rdata", read_data_o, 32'd0);
        rst_i = 1'b1;
        cyc(2);

        // 0xED with ACK
        bus_write(32'h00, 32'hED);
        device_frame(1'b1, seen, ok);
        chk("ed_req_seen", {31'd0, ok}, 32'd1);
        chk("ed_oe_seq", {21'd0, seen}, {21'd0, model_oe(8'hED)});
        wait_irq(ok);
        chk("ed_irq", {31'd0, ok}, 32'd1);
        bus_read(32'h08, rdat);
        chk("ed_flags", rdat, 32'h1);
        bus_read(32'h08, rdat);
        chk("ed_flags_cleared", rdat, 32'h0);
        chk("ed_irq_cleared", {31'd0, interrupt_request_o}, 32'd0);

        // parity boundaries
        foreach (seen[i]) seen[i] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? 8'h00 : 8'h07;
            bus_write(32'h00, {24'd0, b});
            device_frame(1'b1, seen, ok);
            chk("par_oe_seq", {21'd0, seen}, {21'd0, model_oe(b)});
            chk("par_slot", {31'd0, seen[9]}, (k == 0) ? 32'd0 : 32'd1);
            chk("par_capture", {24'd0, captured(seen)}, {24'd0, b});
            wait_irq(ok);
            bus_read(32'h08, rdat);
            chk("par_flags", rdat, 32'h1);
        end

        // randomized bytes, cleared through interrupt_return_i
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom_range(0, 255));
            bus_write(32'h00, {24'd0, b});
            device_frame(1'b1, seen, ok);
            chk("rnd_oe_seq", {21'd0, seen}, {21'd0, model_oe(b)});
            chk("rnd_capture", {24'd0, captured(seen)}, {24'd0, b});
            wait_irq(ok);
            chk("rnd_irq", {31'd0, ok}, 32'd1);
            interrupt_return_i = 1'b1;
            cyc(1);
            interrupt_return_i = 1'b0;
            chk("rnd_irq_return", {31'd0, interrupt_request_o}, 32'd0);
        end

        // NACK
        bus_write(32'h00, 32'h3A);
        device_frame(1'b0, seen, ok);
        wait_irq(ok);
        chk("nack_irq", {31'd0, ok}, 32'd1);
        bus_read(32'h08, rdat);
        chk("nack_flags", rdat, 32'h2);
        bus_read(32'h04, rdat);
        chk("nack_busy", rdat, 32'h0);

        // timeout: device never clocks after the request
        bus_write(32'h00, 32'hFF);
        wait_req(ok);
        chk("to_req_seen", {31'd0, ok}, 32'd1);
        n = 0;
        while (interrupt_request_o !== 1'b1 && n < TIMEOUT + 100) begin
            cyc(1);
            n++;
        end
        chk("to_cycles", n, TIMEOUT);
        chk("to_oe", {30'd0, kclk_oe_o, kdata_oe_o}, 32'd0);
        bus_read(32'h08, rdat);
        chk("to_flags", rdat, 32'h2);

        // write while busy is dropped
        bus_write(32'h00, 32'h3C);
        bus_write(32'h00, 32'h55);
        bus_read(32'h00, rdat);
        chk("drop_txbyte", rdat, 32'h3C);
        device_frame(1'b1, seen, ok);
        chk("drop_oe_seq", {21'd0, seen}, {21'd0, model_oe(8'h3C)});
        wait_irq(ok);
        bus_read(32'h08, rdat);
        chk("drop_flags", rdat, 32'h5);
        bus_read(32'h10, rdat);
        chk("bad_addr", rdat, 32'hdead_beef);

        // soft reset mid-SEND
        bus_write(32'h00, 32'h00);
        wait_req(ok);
        for (int i = 0; i < 3; i++) begin
            dev_fall();
            cyc(2);
            dev_kclk = 1'b1;
        end
        chk("srst_pre_oe", {31'd0, kdata_oe_o}, 32'd1);
        bus_write(32'h24, 32'h1);
        chk("srst_oe", {30'd0, kclk_oe_o, kdata_oe_o}, 32'd0);
        bus_read(32'h04, rdat);
        chk("srst_busy", rdat, 32'h0);
        chk("srst_no_irq", {31'd0, interrupt_request_o}, 32'd0);

        // asynchronous reset mid-SEND
        bus_read(32'h10, rdat);
        bus_write(32'h00, 32'h00);
        wait_req(ok);
        for (int i = 0; i < 2; i++) begin
            dev_fall();
            cyc(2);
            dev_kclk = 1'b1;
        end
        chk("arst_pre_oe", {31'd0, kdata_oe_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_oe", {30'd0, kclk_oe_o, kdata_oe_o}, 32'd0);
        chk("arst_rdata", read_data_o, 32'd0);
        cyc(2);
        rst_i = 1'b1;
        cyc(2);
        bus_read(32'h04, rdat);
        chk("arst_busy", rdat, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_tx_sb_ctrl.md
Name: ps2_tx_sb_ctrl

Overview:
System-bus peripheral that sends single command bytes from the CPU to a PS/2 device, for example keyboard LED-set 0xED or reset 0xFF. It is the host-to-device counterpart of the PS/2 receive controller and shares the same kclk/kdata lines. It drives those lines through open-drain enables, runs the host-to-device frame, checks the device ACK, and raises a completion/error interrupt.

Parameters:
INHIBIT_CYCLES, 1000, clk_i cycles kclk is held low before the request (at least 100 us).
TIMEOUT_CYCLES, 200000, maximum clk_i cycles allowed between consecutive kclk falling edges once the request has started.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-low reset
addr_i  in  32  byte offset within the peripheral
req_i  in  1  bus request
write_data_i  in  32  write data
write_enable_i  in  1  1 = write, 0 = read
read_data_o  out  32  registered read data
interrupt_request_o  out  1  done or error pending
interrupt_return_i  in  1  clears pending flags
kclk_i  in  1  PS/2 clock line level
kdata_i  in  1  PS/2 data line level
kclk_oe_o  out  1  1 = pull kclk low
kdata_oe_o  out  1  1 = pull kdata low

Behaviour:
- Reset: rst_i low asynchronously clears all state.
  - FSM goes to IDLE.
  - kclk_oe_o=0, kdata_oe_o=0, read_data_o=0, interrupt_request_o=0, all flags 0.
- Input conditioning: kclk_i and kdata_i each pass through a 2-flop synchronizer. A kclk falling edge is synchronized previous=1 and current=0.
- Register map:
  - 0x00 write: loads tx_byte with write_data_i[7:0]. It starts a frame only if state is IDLE and write_data_i<=255. A write while busy is ignored and sets `dropped`.
  - 0x00 read: returns {24'd0, tx_byte}.
  - 0x04 read: returns {31'd0, busy}. busy = (state != IDLE).
  - 0x08 read: returns {29'd0, dropped, err, done}. This read clears all three flags.
  - 0x24 write with data==1: synchronous soft reset, same effect as rst_i, taking effect on the next edge.
- Read timing:
  - read_data_o updates one cycle after a read request: the register value for a valid address, 32'hdead_beef for any other address.
  - read_data_o holds its value when there is no read request.
- Odd parity: parity = ~^tx_byte.
- FSM:
  - IDLE: on a start write, load the shift register with {1'b1 stop, parity, tx_byte}, clear done/err, set kclk_oe_o=1, go to INHIBIT.
  - INHIBIT: count INHIBIT_CYCLES, then kdata_oe_o=1 (start bit) and kclk_oe_o=0, go to REQ.
  - REQ: on a kclk falling edge, drive kdata_oe_o = ~shift[0], shift right, bit_cnt=1, go to SEND.
  - SEND: on each falling edge, drive the next bit (kdata_oe_o = ~shift[0]) and increment bit_cnt. The bits go out in order: data bit 0 to bit 7 LSB first, then parity, then stop (line released). After the stop bit (bit_cnt==10) go to ACK.
  - ACK: on the next falling edge, sample synchronized kdata.
    - kdata 0: ACK received, go to WAIT_IDLE.
    - kdata 1: set err, go to IDLE.
  - WAIT_IDLE: when synchronized kclk and kdata are both 1, set done and go to IDLE.
- Timeout:
  - In REQ/SEND/ACK/WAIT_IDLE the timeout counter resets on every falling edge.
  - If the counter reaches TIMEOUT_CYCLES: set err, release both lines, go to IDLE.
- Outside INHIBIT, REQ and SEND both oe outputs are 0.
- interrupt_request_o = done | err. interrupt_return_i clears done and err.
- Simultaneous events: a flag being set wins over a clear in the same cycle. Soft reset wins over everything.
- Soft reset or rst_i during a frame releases both lines immediately (same cycle for rst_i, next edge for soft reset). No flag is set.

Decomposition:
- Shared package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE);
  - register offset constants (0x00, 0x04, 0x08, 0x24);
  - the 32'hdead_beef constant;
  - the odd-parity function.
- One natural sub-module, ps2_line_sync: 2-flop synchronizer plus kclk falling-edge detector. It is reusable by the receiver.

Test Plan:
- Write 0xED to 0x00; device BFM clocks 11 falling edges and drives ACK low.
  -> kdata_oe_o sequence: start 1, then ~bits of 1,0,1,1,0,1,1,1 (LSB first), parity bit 1 -> oe 0, stop -> oe 0.
  -> done=1, interrupt_request_o=1, read 0x08 returns 0x1 then 0x0.
- Write 0x00 -> parity bit is 1, kdata released during the parity slot. Write 0x07 -> parity 0, kdata driven low during parity. BFM captures both bytes correctly.
- BFM leaves kdata high at the ACK edge -> err=1, read 0x08 returns 0x2, busy=0.
- BFM never clocks after REQ -> err set exactly TIMEOUT_CYCLES cycles after the last edge; both oe outputs 0.
- Write 0x55 to 0x00 while busy -> frame continues, tx_byte unchanged; 0x08 later reads 0x5 (dropped + done). Read of 0x10 returns 32'hdead_beef.
- Mid-SEND: write 1 to 0x24, then assert rst_i low -> oe outputs 0 on the next edge (soft reset) and immediately (rst_i); busy=0, read_data_o=0 after rst_i.
